// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the stage-4 CPU port and a host port.
// CPU has priority; starvation and burst counters bound each side's wait.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_whb,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [2:0]        host_whb,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_whb,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

    typedef enum logic {
        OWN_CPU,
        OWN_HOST
    } owner_t;

    owner_t        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d;

    always_comb begin
        host_gnt = 1'b0;
        unique case (owner_q)
            OWN_CPU:  host_gnt = host_req & (~cpu_req | (starve_q == STARVE_TOP));
            OWN_HOST: host_gnt = host_req & (~cpu_req | (burst_q < BURST_TOP));
            default:  host_gnt = 1'b0;
        endcase
    end

    // An idle CPU never writes, even if cpu_we is left high.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we & cpu_req;
        mem_wdata = cpu_wdata;
        mem_whb   = cpu_whb;
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
            mem_whb   = host_whb;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpu_req & host_gnt;

    always_comb begin
        owner_d  = OWN_CPU;
        burst_d  = '0;
        starve_d = '0;
        if (host_gnt) begin
            owner_d = OWN_HOST;
            if (owner_q == OWN_CPU)
                burst_d = BW'(1);
            else if (burst_q == BURST_TOP)
                burst_d = burst_q;
            else
                burst_d = burst_q + BW'(1);
        end else if (host_req & cpu_req) begin
            if (starve_q == STARVE_TOP)
                starve_d = starve_q;
            else
                starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_CPU;
            starve_q    <= '0;
            burst_q     <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            burst_q     <= burst_d;
            host_rvalid <= host_gnt & ~host_we;
            if (host_gnt & ~host_we)
                host_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-addressed memory model.
// Inputs change on negedge, outputs sampled 4ns later, before posedge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  cpu_whb;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata;
    logic [2:0]  host_whb;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [2:0]  mem_whb;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    assign mem_rdata = mem[mem_addr[9:2]];

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_whb    (cpu_whb),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_whb   (host_whb),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_whb    (mem_whb),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        hreq, hwe;
        logic [31:0] haddr, hwd;
        logic        gnt, stall, mwe, rv;
        logic        cc;
        logic [31:0] crd;
        logic        ch;
        logic [31:0] hrd;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic hr, input logic hw,
                         input logic [31:0] ha, input logic [31:0] hd);
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        #4;
        n_vec++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_whb = 3'b010;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_whb = 3'b001;

        tbl[0] = '{1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 1, 0, 32'h20, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h12345678};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678};
        tbl[6] = '{0, 1, 32'h30, 32'hAAAA5555, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0};

        // reset state
        repeat (2) @(negedge clk);
        #4;
        n_vec++;
        chk("rst_gnt", 32'(host_gnt), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_rdata", host_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd,
                  tbl[i].hreq, tbl[i].hwe, tbl[i].haddr, tbl[i].hwd);
            chk($sformatf("v%0d_gnt", i), 32'(host_gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(tbl[i].stall));
            chk($sformatf("v%0d_mwe", i), 32'(mem_we), 32'(tbl[i].mwe));
            chk($sformatf("v%0d_rvalid", i), 32'(host_rvalid), 32'(tbl[i].rv));
            chk($sformatf("v%0d_maddr", i), mem_addr,
                tbl[i].gnt ? tbl[i].haddr : tbl[i].caddr);
            chk($sformatf("v%0d_mwhb", i), 32'(mem_whb),
                tbl[i].gnt ? 32'd1 : 32'd2);
            if (tbl[i].cc) chk($sformatf("v%0d_crd", i), cpu_rdata, tbl[i].crd);
            if (tbl[i].ch) chk($sformatf("v%0d_hrd", i), host_rdata, tbl[i].hrd);
        end

        // starvation then burst limit, then starvation restarts
        for (int k = 0; k <= 20; k++) begin
            logic eg;
            eg = (k >= 8 && k <= 11) || k == 20;
            drive(1, 0, 32'h40, 0, 1, 1, 32'h40, 32'h0BADF00D);
            chk($sformatf("st%0d_gnt", k), 32'(host_gnt), 32'(eg));
            chk($sformatf("st%0d_stall", k), 32'(cpu_stall), 32'(eg));
            chk($sformatf("st%0d_mwe", k), 32'(mem_we), 32'(eg));
            if (!eg)
                chk($sformatf("st%0d_crd", k), cpu_rdata,
                    k < 8 ? 32'h0 : 32'h0BADF00D);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("st_end_gnt", 32'(host_gnt), 32'd0);

        // idle CPU: host bursts past BURST_MAX, cpu_we left high
        for (int k = 0; k < 10; k++) begin
            logic hw;
            hw = (k % 2) == 0;
            drive(0, 1, 32'h10, 32'hFFFFFFFF, 1, hw,
                  32'h80 + 32'(4 * (hw ? k : k - 1)), 32'h100 + 32'(k));
            chk($sformatf("ib%0d_gnt", k), 32'(host_gnt), 32'd1);
            chk($sformatf("ib%0d_stall", k), 32'(cpu_stall), 32'd0);
            chk($sformatf("ib%0d_mwe", k), 32'(mem_we), 32'(hw));
            chk($sformatf("ib%0d_rvalid", k), 32'(host_rvalid),
                32'(k > 0 && hw));
            if (k > 0 && hw)
                chk($sformatf("ib%0d_hrd", k), host_rdata, 32'h100 + 32'(k - 2));
        end
        // burst counter saturated: CPU now wins
        drive(1, 0, 32'h10, 0, 1, 1, 32'h84, 32'h5);
        chk("ib_sat_gnt", 32'(host_gnt), 32'd0);
        chk("ib_sat_stall", 32'(cpu_stall), 32'd0);
        chk("ib_sat_mwe", 32'(mem_we), 32'd0);
        chk("ib_sat_rvalid", 32'(host_rvalid), 32'd1);
        chk("ib_sat_hrd", host_rdata, 32'h108);
        chk("ib_sat_crd", cpu_rdata, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // async reset with a pending read result
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        chk("ar_gnt", 32'(host_gnt), 32'd1);
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        chk("ar_rv_pre", 32'(host_rvalid), 32'd1);
        chk("ar_hrd_pre", host_rdata, 32'h12345678);
        rst = 1'b0;
        #1;
        chk("ar_rv_imm", 32'(host_rvalid), 32'd0);
        chk("ar_hrd_imm", host_rdata, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ar_rv_next", 32'(host_rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        chk("ar_post_gnt", 32'(host_gnt), 32'd0);
        chk("ar_post_stall", 32'(cpu_stall), 32'd0);
        chk("ar_post_crd", cpu_rdata, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter sharing the single data memory between the CPU's stage-4 load/store port and an external host port (program loader / debug access). It sits between the stage-4 controls (address from `alu1`, write data, `MemRW`, `whb`) and `dmem`. The CPU has priority. Bounded starvation and burst counters guarantee host progress. While the host owns the memory, the arbiter stalls the CPU.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 8, consecutive blocked host cycles before a forced host grant (≥1)
- BURST_MAX, 4, maximum consecutive host grants while the CPU is requesting (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- cpu_req  in  1  stage-4 memory access valid (load or store)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_whb  in  3  CPU width/sign code, passed through
- cpu_rdata  out  DATA_W  read data to the stage-4 pipeline register
- cpu_stall  out  1  CPU must hold its stage-4 access
- host_req  in  1  host access request
- host_we  in  1  host write enable
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_whb  in  3  host width code
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid (registered)
- host_rdata  out  DATA_W  host read data (registered)
- mem_addr  out  ADDR_W  to dmem Addr
- mem_we  out  1  to dmem MemRW
- mem_wdata  out  DATA_W  to dmem DataW
- mem_whb  out  3  to dmem whb
- mem_rdata  in  DATA_W  from dmem DataR (combinational read)

## Operation
- State: owner ∈ {CPU, HOST}; starve_cnt 0..STARVE_MAX (saturating); burst_cnt 0..BURST_MAX (saturating).
- Reset values: owner=CPU, starve_cnt=0, burst_cnt=0, host_rvalid=0, host_rdata=0.
- The grant is decided combinationally each cycle:
  - owner=CPU: host_gnt = host_req & (!cpu_req | starve_cnt==STARVE_MAX).
  - owner=HOST: host_gnt = host_req & (!cpu_req | burst_cnt<BURST_MAX).
- Memory mux:
  - host_gnt=1: mem_* = host_*.
  - Otherwise: mem_* = cpu_*, and mem_we = cpu_we & cpu_req. No write occurs when idle.
- cpu_rdata = mem_rdata at all times. It is only meaningful when cpu_req & !cpu_stall.
- cpu_stall = cpu_req & host_gnt.
- Next state:
  - host_gnt=1: owner←HOST, burst_cnt←(owner==CPU ? 1 : sat(burst_cnt+1)), starve_cnt←0.
  - host_gnt=0: owner←CPU, burst_cnt←0. starve_cnt←sat(starve_cnt+1) if host_req & cpu_req, else 0.
- Host read capture: host_rvalid←host_gnt & !host_we; host_rdata←mem_rdata when host_gnt & !host_we, otherwise held.
- The CPU holds cpu_req/addr/data stable while cpu_stall=1. The arbiter performs no CPU write during a stalled cycle.
- The host holds its request until host_gnt. host_req with host_gnt=0 is a no-op.

## Timing
- CPU access latency: 0 cycles when not stalled (same-cycle mux; dmem writes on the clk edge).
- Host access: write completes at the edge ending the host_gnt cycle. Read data appears with host_rvalid=1 one cycle after host_gnt.
- Worst-case host wait under continuous cpu_req: STARVE_MAX+1 cycles to first grant.
- Worst-case CPU stall under continuous host_req: BURST_MAX cycles, after which the CPU is granted at least one cycle.
- Simultaneous requests with starve_cnt<STARVE_MAX and owner=CPU: the CPU wins.
- Reset asserted mid-burst:
  - Counters, owner and host_rvalid clear immediately.
  - A pending host_rvalid is discarded.
  - Combinational outputs follow the inputs with owner=CPU.

## Test plan
- Reset, CPU only: cpu_req=1, cpu_we=1, addr 0x10, data 0xDEADBEEF; then read 0x10 → mem_we=1 on the first cycle, cpu_rdata=0xDEADBEEF, cpu_stall=0 and host_gnt=0 throughout.
- Host only, idle CPU: host writes 0x20←0x12345678, then reads 0x20 → host_gnt=1 on each request cycle, host_rvalid=1 one cycle after the read with host_rdata=0x12345678, cpu_stall=0.
- Starvation: cpu_req=1 continuous, host_req=1 from cycle 0 → host_gnt=0 for cycles 0–7, host_gnt=1 and cpu_stall=1 at cycle 8 (STARVE_MAX=8).
- Burst limit: continuation of the previous case with host_req held → host_gnt=1 for exactly 4 consecutive cycles, then host_gnt=0 and cpu_stall=0 for 1 cycle, then the starvation count restarts.
- Idle-CPU unlimited burst: cpu_req=0, host_req=1 for 10 cycles → host_gnt=1 all 10 cycles, burst_cnt saturates at 4, no CPU write (mem_we follows host_we only).
- Async reset mid-burst: drop rst during a host read grant → host_rvalid=0 on the next cycle, owner=CPU; after release, simultaneous cpu_req and host_req give host_gnt=0.
